// File: rtl/wb_ctrl_if.sv
// Register-file writeback bundle: pipeline and long-latency result inputs,
// issue/decode scoreboard queries, and the registered regfile write port.
interface wb_ctrl_if;
   logic        a_valid;
   logic [4:0]  a_rd;
   logic [31:0] a_data;
   logic        b_valid;
   logic        b_ready;
   logic [4:0]  b_rd;
   logic [31:0] b_data;
   logic        iss_valid;
   logic [4:0]  iss_rd;
   logic [4:0]  dec_rs1;
   logic [4:0]  dec_rs2;
   logic [4:0]  dec_rd;
   logic        dec_stall;
   logic        pipe_hold;
   logic        we;
   logic [4:0]  rd_addr;
   logic [31:0] wdata;

   modport master (
      output a_valid, a_rd, a_data, b_valid, b_rd, b_data,
      output iss_valid, iss_rd, dec_rs1, dec_rs2, dec_rd,
      input  b_ready, dec_stall, pipe_hold, we, rd_addr, wdata
   );

   modport slave (
      input  a_valid, a_rd, a_data, b_valid, b_rd, b_data,
      input  iss_valid, iss_rd, dec_rs1, dec_rs2, dec_rd,
      output b_ready, dec_stall, pipe_hold, we, rd_addr, wdata
   );
endinterface

// File: rtl/wb_ctrl.sv
// Regfile write-port arbiter: in-order pipeline writes beat queued long-latency
// results; a busy scoreboard stalls decode on pending long-latency destinations.
module wb_ctrl_chk (
   input logic clk,
   input logic rst_n,
   input logic a_valid,
   input logic pipe_hold
);
   // Pipeline must not present a writeback while it is being held off.
   a_during_hold: assert property (@(posedge clk) disable iff (!rst_n) !(pipe_hold && a_valid))
      else $error("a_valid asserted while pipe_hold is high");
endmodule

module wb_ctrl #(
   parameter int DEPTH      = 2,
   parameter int STARVE_LIM = 4
) (
   input logic        clk,
   input logic        rst_n,
   wb_ctrl_if.slave   bus
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int SC_W  = $clog2(STARVE_LIM) + 1;
   localparam logic [SC_W-1:0]  LIM_M1 = SC_W'(STARVE_LIM - 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   typedef struct packed {
      logic [4:0]  rd;
      logic [31:0] data;
   } entry_t;

   entry_t            mem_q [DEPTH];
   entry_t            mem_d [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [SC_W-1:0]   starve_q, starve_d;
   logic              pipe_hold_q, pipe_hold_d;
   logic              we_q, we_d, from_b_q, from_b_d;
   logic [4:0]        rd_addr_q, rd_addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [31:0]       busy_q, busy_d;
   logic [31:0]       clr_vec, set_vec;

   logic   empty, full, sel_a, pop, push;
   entry_t head;

   assign empty = (count_q == {CNT_W{1'b0}});
   assign full  = (count_q == FULL_CNT);
   assign head  = mem_q[rd_ptr_q];
   assign sel_a = bus.a_valid && (bus.a_rd != 5'd0);
   assign pop   = !sel_a && !empty;
   // rd=0 results are handshaken but dropped: x0 is never written.
   assign push  = bus.b_valid && !full && (bus.b_rd != 5'd0);

   assign bus.b_ready   = !full;
   assign bus.dec_stall = busy_q[bus.dec_rs1] | busy_q[bus.dec_rs2] | busy_q[bus.dec_rd];
   assign bus.pipe_hold = pipe_hold_q;
   assign bus.we        = we_q;
   assign bus.rd_addr   = rd_addr_q;
   assign bus.wdata     = wdata_q;

   // Write-port selection: A first, then FIFO head; address/data hold when idle.
   always_comb begin
      we_d      = 1'b0;
      from_b_d  = 1'b0;
      rd_addr_d = rd_addr_q;
      wdata_d   = wdata_q;
      if (sel_a) begin
         we_d      = 1'b1;
         rd_addr_d = bus.a_rd;
         wdata_d   = bus.a_data;
      end else if (pop) begin
         we_d      = 1'b1;
         from_b_d  = 1'b1;
         rd_addr_d = head.rd;
         wdata_d   = head.data;
      end else begin
         we_d      = 1'b0;
      end
   end

   // Result FIFO pointer, storage and occupancy update.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      if (push) begin
         mem_d[wr_ptr_q] = '{rd: bus.b_rd, data: bus.b_data};
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      rd_ptr_d = pop ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
      case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   // Starvation tracking: hold the pipeline once the head has waited too long.
   always_comb begin
      starve_d    = starve_q;
      pipe_hold_d = 1'b0;
      if (pop || empty) begin
         starve_d    = {SC_W{1'b0}};
         pipe_hold_d = 1'b0;
      end else begin
         starve_d    = (starve_q >= LIM_M1) ? starve_q : (starve_q + SC_W'(1));
         pipe_hold_d = (starve_q >= LIM_M1);
      end
   end

   // Scoreboard: a B write landing clears its bit; a same-cycle issue re-sets it.
   always_comb begin
      clr_vec = (we_q && from_b_q) ? (32'd1 << rd_addr_q) : 32'd0;
      set_vec = (bus.iss_valid && (bus.iss_rd != 5'd0)) ? (32'd1 << bus.iss_rd) : 32'd0;
      busy_d  = ((busy_q & ~clr_vec) | set_vec) & ~32'd1;
   end

   // State registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '{rd: 5'd0, data: 32'd0};
         end
         wr_ptr_q    <= {PTR_W{1'b0}};
         rd_ptr_q    <= {PTR_W{1'b0}};
         count_q     <= {CNT_W{1'b0}};
         starve_q    <= {SC_W{1'b0}};
         pipe_hold_q <= 1'b0;
         we_q        <= 1'b0;
         from_b_q    <= 1'b0;
         rd_addr_q   <= 5'd0;
         wdata_q     <= 32'd0;
         busy_q      <= 32'd0;
      end else begin
         mem_q       <= mem_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         starve_q    <= starve_d;
         pipe_hold_q <= pipe_hold_d;
         we_q        <= we_d;
         from_b_q    <= from_b_d;
         rd_addr_q   <= rd_addr_d;
         wdata_q     <= wdata_d;
         busy_q      <= busy_d;
      end
   end

   wb_ctrl_chk u_chk (
      .clk       (clk),
      .rst_n     (rst_n),
      .a_valid   (bus.a_valid),
      .pipe_hold (pipe_hold_q)
   );
endmodule

// File: tb/tb_wb_ctrl.sv
// Directed and randomized bench for wb_ctrl against a queue-based reference model.
module tb_wb_ctrl;
   localparam int DEPTH = 2;
   localparam int LIM   = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   wb_ctrl_if bus ();

   wb_ctrl #(.DEPTH(DEPTH), .STARVE_LIM(LIM)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model state
   logic        m_we, m_from_b, m_hold;
   logic [4:0]  m_rd;
   logic [31:0] m_data;
   logic [31:0] m_busy;
   logic [36:0] fifo[$];
   int          waited;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_we = 1'b0; m_from_b = 1'b0; m_hold = 1'b0;
      m_rd = 5'd0; m_data = 32'd0; m_busy = 32'd0;
      fifo.delete();
      waited = 0;
   endtask

   // Evaluate one clock edge of the reference behaviour from the current inputs.
   task automatic model_edge();
      int pre_size;
      logic popped, accept;
      logic [36:0] e;
      pre_size = fifo.size();
      accept   = bus.b_valid && (pre_size < DEPTH);
      if (m_we && m_from_b) m_busy[m_rd] = 1'b0;
      popped = 1'b0;
      if (bus.a_valid && bus.a_rd != 5'd0) begin
         m_we = 1'b1; m_from_b = 1'b0; m_rd = bus.a_rd; m_data = bus.a_data;
      end else if (pre_size > 0) begin
         e = fifo.pop_front();
         popped = 1'b1;
         m_we = 1'b1; m_from_b = 1'b1; m_rd = e[36:32]; m_data = e[31:0];
      end else begin
         m_we = 1'b0; m_from_b = 1'b0;
      end
      if (accept && bus.b_rd != 5'd0) fifo.push_back({bus.b_rd, bus.b_data});
      if (popped || pre_size == 0) begin
         waited = 0; m_hold = 1'b0;
      end else begin
         waited++;
         m_hold = (waited >= LIM);
      end
      if (bus.iss_valid && bus.iss_rd != 5'd0) m_busy[bus.iss_rd] = 1'b1;
      m_busy[0] = 1'b0;
   endtask

   task automatic check_outs(input string tag);
      logic exp_stall;
      exp_stall = m_busy[bus.dec_rs1] | m_busy[bus.dec_rs2] | m_busy[bus.dec_rd];
      chk({tag, ".we"},        32'(bus.we),        32'(m_we));
      chk({tag, ".rd_addr"},   32'(bus.rd_addr),   32'(m_rd));
      chk({tag, ".wdata"},     bus.wdata,          m_data);
      chk({tag, ".pipe_hold"}, 32'(bus.pipe_hold), 32'(m_hold));
      chk({tag, ".b_ready"},   32'(bus.b_ready),   32'(fifo.size() < DEPTH));
      chk({tag, ".dec_stall"}, 32'(bus.dec_stall), 32'(exp_stall));
   endtask

   task automatic cyc(input string tag);
      model_edge();
      @(posedge clk);
      #1;
      check_outs(tag);
   endtask

   task automatic idle();
      bus.a_valid = 1'b0; bus.a_rd = 5'd0; bus.a_data = 32'd0;
      bus.b_valid = 1'b0; bus.b_rd = 5'd0; bus.b_data = 32'd0;
      bus.iss_valid = 1'b0; bus.iss_rd = 5'd0;
      bus.dec_rs1 = 5'd0; bus.dec_rs2 = 5'd0; bus.dec_rd = 5'd0;
   endtask

   initial begin
      int guard;
      idle();
      model_reset();
      #12;
      chk("rst.we",        32'(bus.we),        32'd0);
      chk("rst.b_ready",   32'(bus.b_ready),   32'd1);
      chk("rst.pipe_hold", 32'(bus.pipe_hold), 32'd0);
      check_outs("rst");
      rst_n = 1'b1;

      // A-only writeback, then a_rd=0
      bus.a_valid = 1'b1; bus.a_rd = 5'd5; bus.a_data = 32'hDEADBEEF;
      cyc("a_only");
      chk("a_only.we_k",    32'(bus.we),      32'd1);
      chk("a_only.rd_k",    32'(bus.rd_addr), 32'd5);
      chk("a_only.data_k",  bus.wdata,        32'hDEADBEEF);
      bus.a_rd = 5'd0;
      cyc("a_rd0");
      chk("a_rd0.we_k", 32'(bus.we), 32'd0);

      // Priority: A and B together, B follows
      bus.a_valid = 1'b1; bus.a_rd = 5'd3; bus.a_data = 32'h0000_3333;
      bus.b_valid = 1'b1; bus.b_rd = 5'd7; bus.b_data = 32'h0000_0011;
      cyc("prio1");
      chk("prio1.rd_k", 32'(bus.rd_addr), 32'd3);
      idle();
      cyc("prio2");
      chk("prio2.rd_k",   32'(bus.rd_addr), 32'd7);
      chk("prio2.data_k", bus.wdata,        32'h0000_0011);
      cyc("prio3");

      // Scoreboard: issue x9, stall until the B result lands, re-issue in clear cycle
      bus.iss_valid = 1'b1; bus.iss_rd = 5'd9;
      cyc("sb_iss");
      bus.iss_valid = 1'b0; bus.dec_rs1 = 5'd9;
      #1 chk("sb_stall_k", 32'(bus.dec_stall), 32'd1);
      cyc("sb_wait");
      bus.b_valid = 1'b1; bus.b_rd = 5'd9; bus.b_data = 32'h0909_0909;
      cyc("sb_push");
      bus.b_valid = 1'b0;
      cyc("sb_land");
      chk("sb_land.rd_k",    32'(bus.rd_addr),   32'd9);
      chk("sb_land.stall_k", 32'(bus.dec_stall), 32'd1);
      bus.iss_valid = 1'b1; bus.iss_rd = 5'd9;
      cyc("sb_reiss");
      chk("sb_reiss.stall_k", 32'(bus.dec_stall), 32'd1);
      bus.iss_valid = 1'b0;
      bus.b_valid = 1'b1; bus.b_rd = 5'd9; bus.b_data = 32'h0000_0099;
      cyc("sb_push2");
      bus.b_valid = 1'b0;
      cyc("sb_land2");
      cyc("sb_clear");
      chk("sb_clear.stall_k", 32'(bus.dec_stall), 32'd0);
      idle();

      // Full FIFO and starvation hold
      bus.a_valid = 1'b1; bus.a_rd = 5'd4; bus.a_data = $urandom;
      bus.b_valid = 1'b1; bus.b_rd = 5'd12; bus.b_data = 32'hC0C0_0012;
      cyc("full1");
      bus.b_rd = 5'd13; bus.b_data = 32'hC0C0_0013;
      cyc("full2");
      bus.b_valid = 1'b0;
      chk("full.bready_k", 32'(bus.b_ready), 32'd0);
      guard = 0;
      while (!bus.pipe_hold && guard < 20) begin
         bus.a_data = $urandom;
         cyc("starve");
         guard++;
      end
      chk("starve.hold_k", 32'(bus.pipe_hold), 32'd1);
      bus.a_valid = 1'b0;
      cyc("drain1");
      chk("drain1.rd_k",   32'(bus.rd_addr),   32'd12);
      chk("drain1.hold_k", 32'(bus.pipe_hold), 32'd0);
      cyc("drain2");
      chk("drain2.rd_k",   32'(bus.rd_addr), 32'd13);
      chk("drain2.bready", 32'(bus.b_ready), 32'd1);
      cyc("drain3");

      // Wrap: ten back-to-back B results
      for (int i = 0; i < 10; i++) begin
         bus.b_valid = 1'b1; bus.b_rd = 5'(i + 1); bus.b_data = $urandom;
         cyc("wrap");
      end
      idle();
      cyc("wrap_end1");
      cyc("wrap_end2");

      // Random traffic with a mid-stream asynchronous reset
      for (int i = 0; i < 400; i++) begin
         bus.a_valid   = ($urandom_range(0, 2) == 0) && !m_hold;
         bus.a_rd      = 5'($urandom_range(0, 31));
         bus.a_data    = $urandom;
         bus.b_valid   = ($urandom_range(0, 1) == 0);
         bus.b_rd      = 5'($urandom_range(0, 31));
         bus.b_data    = $urandom;
         bus.iss_valid = ($urandom_range(0, 3) == 0);
         bus.iss_rd    = 5'($urandom_range(0, 31));
         bus.dec_rs1   = 5'($urandom_range(0, 31));
         bus.dec_rs2   = 5'($urandom_range(0, 31));
         bus.dec_rd    = 5'($urandom_range(0, 31));
         cyc("rand");
         if (i == 200) begin
            rst_n = 1'b0;
            #1;
            model_reset();
            chk("mrst.we",        32'(bus.we),        32'd0);
            chk("mrst.b_ready",   32'(bus.b_ready),   32'd1);
            chk("mrst.dec_stall", 32'(bus.dec_stall), 32'd0);
            chk("mrst.pipe_hold", 32'(bus.pipe_hold), 32'd0);
            #1 rst_n = 1'b1;
         end
      end
      idle();
      for (int i = 0; i < 4; i++) cyc("final");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
